// File: rtl/cmp_pkg.sv
// Shared types and default widths for the golden-vs-netlist response checker.
//   cmp_state_e : checker FSM state encoding
//   CMP_*_W     : default widths used as parameter defaults by cmp_resp_checker
package cmp_pkg;

    localparam int unsigned CMP_DIN_W = 8;   // stimulus vector width
    localparam int unsigned CMP_OUT_W = 1;   // compared DUT output width
    localparam int unsigned CMP_CNT_W = 16;  // vector / mismatch counter width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } cmp_state_e;

endpackage : cmp_pkg

// File: rtl/cmp_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : increment by one, holding at all-ones
//   cnt        : registered count
module cmp_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : cmp_sat_counter

// File: rtl/cmp_resp_checker.sv
// Response checker for golden-vs-netlist equivalence runs. Accepts one
// stimulus vector per valid/ready handshake, waits SETTLE cycles, compares
// golden against netlist and accumulates statistics into a pass/fail verdict.
// Optional feature macro: CMP_FIRST_FAIL_EN builds the first-fail record;
// without it first_fail_* are tied to zero.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, num_vec    : run start pulse and vector count (sampled on accept)
//   stim_valid/ready  : stimulus handshake; stim_data recorded for first-fail
//   golden, netlist   : compared DUT outputs
//   busy, done, pass  : run status and verdict
//   vec_cnt           : vectors compared this run
//   mismatch_cnt      : mismatching vectors (saturating)
//   first_fail_*      : index and stimulus of the first mismatching vector
module cmp_resp_checker
    import cmp_pkg::*;
#(
    parameter int unsigned DIN_W  = CMP_DIN_W,
    parameter int unsigned OUT_W  = CMP_OUT_W,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = CMP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             stim_valid,
    output logic             stim_ready,
    input  logic [DIN_W-1:0] stim_data,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] netlist,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [DIN_W-1:0] first_fail_vec
);

    // Settle timer counts SETTLE-1 down to 0 while in ST_SETTLE
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = (SETTLE == 0) ? '0 : SET_W'(SETTLE - 1);

    cmp_state_e       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             stim_ready_q, stim_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             clr_c;
    logic             accept_c;
    logic             cmp_c;
    logic             miss_c;
    logic             last_c;

    // Handshake and compare qualifiers
    assign accept_c = (state_q == ST_RUN) && stim_valid && stim_ready_q;
    assign cmp_c    = (state_q == ST_COMPARE);
    assign miss_c   = cmp_c && (golden != netlist);
    assign last_c   = (vec_cnt + CNT_W'(1)) == num_q;

    // Next-state, timer, run parameters and registered status outputs
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        num_d    = num_q;
        pass_d   = pass_q;
        clr_c    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_c   = 1'b1;
                    num_d   = num_vec;
                    pass_d  = (num_vec == '0);
                    state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    settle_d = SET_LOAD;
                    state_d  = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_COMPARE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_COMPARE: begin
                if (last_c) begin
                    state_d = ST_DONE;
                    // Verdict folds in this cycle's compare result
                    pass_d  = (mismatch_cnt == '0) && !miss_c;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stim_ready_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RUN) || (state_d == ST_SETTLE) ||
                       (state_d == ST_COMPARE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            num_q        <= '0;
            stim_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            num_q        <= num_d;
            stim_ready_q <= stim_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // Vectors compared this run
    cmp_sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .inc   (cmp_c),
        .cnt   (vec_cnt)
    );

    // Mismatching vectors, saturating at all-ones
    cmp_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .inc   (miss_c),
        .cnt   (mismatch_cnt)
    );

`ifdef CMP_FIRST_FAIL_EN
    logic [DIN_W-1:0] stim_q, stim_d;
    logic             ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [DIN_W-1:0] ff_vec_q, ff_vec_d;

    // Latch the accepted vector; capture index/vector on the first mismatch
    always_comb begin
        stim_d     = stim_q;
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_vec_d   = ff_vec_q;
        if (accept_c) begin
            stim_d = stim_data;
        end
        if (clr_c) begin
            ff_valid_d = 1'b0;
            ff_idx_d   = '0;
            ff_vec_d   = '0;
        end else if (miss_c && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = vec_cnt;
            ff_vec_d   = stim_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_vec_q   <= '0;
        end else begin
            stim_q     <= stim_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_vec   = ff_vec_q;
`else
    // Stimulus is only recorded for the first-fail record, absent here
    logic unused_stim;
    assign unused_stim      = ^stim_data;
    assign first_fail_valid = 1'b0;
    assign first_fail_idx   = '0;
    assign first_fail_vec   = '0;
`endif

    assign stim_ready = stim_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule : cmp_resp_checker
